// File: rtl/branch_lookup_table.sv
// branch_lookup_table
// Small fully-associative branch target table for next-PC prediction.
// Fetch looks up read_key combinationally. The EX-stage resolver writes the
// table: hit=1 inserts or updates an entry, and hit=0 invalidates it.
// When the table is full, the entry at a round-robin victim pointer is
// replaced.
// Optional feature: define BLT_WRITE_BYPASS_EN to forward a same-cycle write
// to a read of the same key.
module branch_lookup_table #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] write_key,
  input  logic [ADDR_WIDTH-1:0] write_val,
  input  logic                  hit,
  input  logic [ADDR_WIDTH-1:0] read_key,
  output logic [ADDR_WIDTH-1:0] read_val,
  output logic                  read_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Table state
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] key_q [DEPTH];
  logic [ADDR_WIDTH-1:0] key_d [DEPTH];
  logic [ADDR_WIDTH-1:0] val_q [DEPTH];
  logic [ADDR_WIDTH-1:0] val_d [DEPTH];
  logic [PTR_W-1:0]      ptr_q, ptr_d;

  // Lookup helpers
  logic [DEPTH-1:0]      rd_match_s;
  logic [ADDR_WIDTH-1:0] rd_val_s;
  logic [DEPTH-1:0]      wr_match_s;
  logic [PTR_W-1:0]      wr_idx_s;
  logic                  wr_present_s;
  logic [PTR_W-1:0]      free_idx_s;
  logic                  free_any_s;

  // Read port: one-hot match against valid keys, AND-OR mux of stored targets
  always_comb begin
    rd_val_s = {ADDR_WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      rd_match_s[i] = valid_q[i] & (key_q[i] == read_key);
      rd_val_s      = rd_val_s | (val_q[i] & {ADDR_WIDTH{rd_match_s[i]}});
    end
  end

  // Output select: registered contents, optionally overridden by a same-key write
  always_comb begin
    read_valid = |rd_match_s;
    read_val   = rd_val_s;
`ifdef BLT_WRITE_BYPASS_EN
    if (write && reset && (read_key == write_key)) begin
      read_valid = hit;
      read_val   = hit ? write_val : {ADDR_WIDTH{1'b0}};
    end else begin
      read_valid = |rd_match_s;
      read_val   = rd_val_s;
    end
`endif
  end

  // Write-side search: index of the matching entry and of the lowest free entry
  always_comb begin
    wr_idx_s   = {PTR_W{1'b0}};
    free_idx_s = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      wr_match_s[i] = valid_q[i] & (key_q[i] == write_key);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_match_s[i]) begin
        wr_idx_s = PTR_W'(i);
      end else begin
        wr_idx_s = wr_idx_s;
      end
    end
    // Scan downward so that the lowest free index is the last one assigned
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx_s = PTR_W'(i);
      end else begin
        free_idx_s = free_idx_s;
      end
    end
    wr_present_s = |wr_match_s;
    free_any_s   = ~(&valid_q);
  end

  // Next-state: update, fill free slot, round-robin replace, or invalidate
  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    val_d   = val_q;
    ptr_d   = ptr_q;
    if (write) begin
      if (hit) begin
        if (wr_present_s) begin
          val_d[wr_idx_s] = write_val;
        end else if (free_any_s) begin
          valid_d[free_idx_s] = 1'b1;
          key_d[free_idx_s]   = write_key;
          val_d[free_idx_s]   = write_val;
        end else begin
          key_d[ptr_q] = write_key;
          val_d[ptr_q] = write_val;
          ptr_d        = ptr_q + PTR_W'(1);
        end
      end else begin
        if (wr_present_s) begin
          valid_d[wr_idx_s] = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers; synchronous active-low reset clears valids and pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= {DEPTH{1'b0}};
      ptr_q   <= {PTR_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  // Key/target storage; contents are don't-care while the valid bits are clear
  always_ff @(posedge clk) begin
    key_q <= key_d;
    val_q <= val_d;
  end

endmodule

// File: tb/tb_branch_lookup_table.sv
// Directed self-checking bench for branch_lookup_table (ADDR_WIDTH=16, DEPTH=8).
module tb_branch_lookup_table;

  logic        clk;
  logic        reset;
  logic        write;
  logic [15:0] write_key;
  logic [15:0] write_val;
  logic        hit;
  logic [15:0] read_key;
  logic [15:0] read_val;
  logic        read_valid;

  int n_checks;
  int n_fail;

  branch_lookup_table #(.ADDR_WIDTH(16), .DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .write      (write),
    .write_key  (write_key),
    .write_val  (write_val),
    .hit        (hit),
    .read_key   (read_key),
    .read_val   (read_val),
    .read_valid (read_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] k, input logic [15:0] v, input logic h);
    write     = 1'b1;
    write_key = k;
    write_val = v;
    hit       = h;
    tick();
    write     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    write = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] keys [3];
    keys[0] = 16'h0000;
    keys[1] = 16'h0010;
    keys[2] = 16'hFFFF;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      read_key = keys[i];
      #1;
      n_checks++;
      if (read_valid !== 1'b0 || read_val !== 16'h0000) begin
        $display("FAIL reset_read key=%h got valid=%b val=%h want valid=0 val=0000",
                 keys[i], read_valid, read_val);
        n_fail++;
      end
    end
  endtask

  task automatic test_insert();
    do_write(16'h0010, 16'h0040, 1'b1);
    read_key = 16'h0010;
    #1;
    n_checks++;
    if (read_valid !== 1'b1 || read_val !== 16'h0040) begin
      $display("FAIL insert_hit got valid=%b val=%h want 1/0040", read_valid, read_val);
      n_fail++;
    end
    read_key = 16'h0011;
    #1;
    n_checks++;
    if (read_valid !== 1'b0 || read_val !== 16'h0000) begin
      $display("FAIL insert_neighbor_miss got valid=%b val=%h want 0/0000", read_valid, read_val);
      n_fail++;
    end
  endtask

  task automatic test_update_invalidate();
    do_write(16'h0010, 16'h0055, 1'b1);
    do_write(16'h0020, 16'h0077, 1'b1);
    read_key = 16'h0010;
    #1;
    n_checks++;
    if (read_valid !== 1'b1 || read_val !== 16'h0055) begin
      $display("FAIL update got valid=%b val=%h want 1/0055", read_valid, read_val);
      n_fail++;
    end
    // Invalidate of an absent key changes nothing
    do_write(16'h0099, 16'h1234, 1'b0);
    read_key = 16'h0099;
    #1;
    n_checks++;
    if (read_valid !== 1'b0 || read_val !== 16'h0000) begin
      $display("FAIL inval_absent_miss got valid=%b val=%h want 0/0000", read_valid, read_val);
      n_fail++;
    end
    read_key = 16'h0020;
    #1;
    n_checks++;
    if (read_valid !== 1'b1 || read_val !== 16'h0077) begin
      $display("FAIL inval_absent_keep got valid=%b val=%h want 1/0077", read_valid, read_val);
      n_fail++;
    end
    do_write(16'h0010, 16'h0000, 1'b0);
    read_key = 16'h0010;
    #1;
    n_checks++;
    if (read_valid !== 1'b0 || read_val !== 16'h0000) begin
      $display("FAIL invalidate got valid=%b val=%h want 0/0000", read_valid, read_val);
      n_fail++;
    end
    read_key = 16'h0020;
    #1;
    n_checks++;
    if (read_valid !== 1'b1 || read_val !== 16'h0077) begin
      $display("FAIL invalidate_other got valid=%b val=%h want 1/0077", read_valid, read_val);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    do_write(16'h0050, 16'h0001, 1'b1);
    do_write(16'h0050, 16'h0002, 1'b1);
    read_key = 16'h0050;
    #1;
    n_checks++;
    if (read_valid !== 1'b1 || read_val !== 16'h0002) begin
      $display("FAIL back_to_back got valid=%b val=%h want 1/0002", read_valid, read_val);
      n_fail++;
    end
  endtask

  task automatic test_eviction();
    logic [15:0] k;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      k = 16'(i);
      do_write(k, k + 16'h0100, 1'b1);
    end
    for (int i = 1; i <= 8; i++) begin
      k = 16'(i);
      read_key = k;
      #1;
      n_checks++;
      if (read_valid !== 1'b1 || read_val !== (k + 16'h0100)) begin
        $display("FAIL fill_read key=%h got valid=%b val=%h want 1/%h",
                 k, read_valid, read_val, k + 16'h0100);
        n_fail++;
      end
    end
    do_write(16'h0009, 16'h0109, 1'b1);
    read_key = 16'h0001;
    #1;
    n_checks++;
    if (read_valid !== 1'b0 || read_val !== 16'h0000) begin
      $display("FAIL evict1 got valid=%b val=%h want 0/0000", read_valid, read_val);
      n_fail++;
    end
    read_key = 16'h0009;
    #1;
    n_checks++;
    if (read_valid !== 1'b1 || read_val !== 16'h0109) begin
      $display("FAIL new9 got valid=%b val=%h want 1/0109", read_valid, read_val);
      n_fail++;
    end
    do_write(16'h000A, 16'h010A, 1'b1);
    read_key = 16'h0002;
    #1;
    n_checks++;
    if (read_valid !== 1'b0 || read_val !== 16'h0000) begin
      $display("FAIL evict2 got valid=%b val=%h want 0/0000", read_valid, read_val);
      n_fail++;
    end
    read_key = 16'h0003;
    #1;
    n_checks++;
    if (read_valid !== 1'b1 || read_val !== 16'h0103) begin
      $display("FAIL keep3_before got valid=%b val=%h want 1/0103", read_valid, read_val);
      n_fail++;
    end
    // Freed slot must be reused instead of evicting at the pointer (slot of key 3)
    do_write(16'h0005, 16'h0000, 1'b0);
    do_write(16'h000B, 16'h010B, 1'b1);
    read_key = 16'h000B;
    #1;
    n_checks++;
    if (read_valid !== 1'b1 || read_val !== 16'h010B) begin
      $display("FAIL newB got valid=%b val=%h want 1/010b", read_valid, read_val);
      n_fail++;
    end
    read_key = 16'h0003;
    #1;
    n_checks++;
    if (read_valid !== 1'b1 || read_val !== 16'h0103) begin
      $display("FAIL keep3_after got valid=%b val=%h want 1/0103", read_valid, read_val);
      n_fail++;
    end
    read_key = 16'h0005;
    #1;
    n_checks++;
    if (read_valid !== 1'b0) begin
      $display("FAIL gone5 got valid=%b want 0", read_valid);
      n_fail++;
    end
    // Table full again: next insert evicts at pointer=2 (key 3)
    do_write(16'h000C, 16'h010C, 1'b1);
    read_key = 16'h0003;
    #1;
    n_checks++;
    if (read_valid !== 1'b0) begin
      $display("FAIL evict3 got valid=%b want 0", read_valid);
      n_fail++;
    end
    read_key = 16'h000C;
    #1;
    n_checks++;
    if (read_valid !== 1'b1 || read_val !== 16'h010C) begin
      $display("FAIL newC got valid=%b val=%h want 1/010c", read_valid, read_val);
      n_fail++;
    end
  endtask

  task automatic test_same_cycle();
    logic        exp_v;
    logic [15:0] exp_d;
`ifdef BLT_WRITE_BYPASS_EN
    exp_v = 1'b1;
    exp_d = 16'h0030;
`else
    exp_v = 1'b0;
    exp_d = 16'h0000;
`endif
    do_reset();
    write     = 1'b1;
    write_key = 16'h0020;
    write_val = 16'h0030;
    hit       = 1'b1;
    read_key  = 16'h0020;
    #1;
    n_checks++;
    if (read_valid !== exp_v || read_val !== exp_d) begin
      $display("FAIL same_cycle got valid=%b val=%h want %b/%h", read_valid, read_val, exp_v, exp_d);
      n_fail++;
    end
    tick();
    write = 1'b0;
    #1;
    n_checks++;
    if (read_valid !== 1'b1 || read_val !== 16'h0030) begin
      $display("FAIL next_cycle got valid=%b val=%h want 1/0030", read_valid, read_val);
      n_fail++;
    end
  endtask

  task automatic test_reset_wins();
    reset     = 1'b0;
    write     = 1'b1;
    write_key = 16'h0040;
    write_val = 16'h0041;
    hit       = 1'b1;
    tick();
    reset = 1'b1;
    write = 1'b0;
    read_key = 16'h0040;
    #1;
    n_checks++;
    if (read_valid !== 1'b0 || read_val !== 16'h0000) begin
      $display("FAIL reset_wins got valid=%b val=%h want 0/0000", read_valid, read_val);
      n_fail++;
    end
    read_key = 16'h0020;
    #1;
    n_checks++;
    if (read_valid !== 1'b0 || read_val !== 16'h0000) begin
      $display("FAIL reset_clears got valid=%b val=%h want 0/0000", read_valid, read_val);
      n_fail++;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    write     = 1'b0;
    write_key = 16'h0000;
    write_val = 16'h0000;
    hit       = 1'b0;
    read_key  = 16'h0000;
    test_reset();
    test_insert();
    test_update_invalidate();
    test_back_to_back();
    test_eviction();
    test_same_cycle();
    test_reset_wins();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
